// File: rtl/dot_prod_unit.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | dot_prod_unit: NROW parallel fixed-point MACs over a column weight memory.  |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module dot_prod_unit #(
    parameter int NROW            = 16,
    parameter int NCOL            = 4,
    parameter int QN              = 6,
    parameter int QM              = 11,
    parameter int DSP48_PER_ROW   = 2,
    parameter int BITWIDTH        = QN + QM + 1,
    parameter int MEMORY_BITWIDTH = BITWIDTH * NROW,
    parameter int ADDR_BITWIDTH   = $clog2(NCOL)
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic [ADDR_BITWIDTH-1:0]   colAddressWrite,
    input  logic                       writeEn,
    input  logic [MEMORY_BITWIDTH-1:0] weightMemInput,
    input  logic [BITWIDTH-1:0]        inputVec,
    output logic [ADDR_BITWIDTH-1:0]   colAddressRead,
    output logic [MEMORY_BITWIDTH-1:0] outputVec,
    output logic                       dataReady
);

    localparam int ACC_W = 2 * BITWIDTH + ADDR_BITWIDTH;
    localparam logic [ADDR_BITWIDTH-1:0] LAST_COL = ADDR_BITWIDTH'(NCOL - 1);
    localparam logic signed [ACC_W-1:0] SAT_MAX =
        {{(ACC_W - BITWIDTH + 1){1'b0}}, {(BITWIDTH - 1){1'b1}}};
    localparam logic signed [ACC_W-1:0] SAT_MIN =
        {{(ACC_W - BITWIDTH + 1){1'b1}}, {(BITWIDTH - 1){1'b0}}};

    typedef enum logic [1:0] {
        ST_ACC  = 2'd0,
        ST_OUT  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t                     state;
    state_t                     state_next;
    logic                       acc_en;
    logic                       out_load;
    logic [MEMORY_BITWIDTH-1:0] weight_mem [NCOL];
    logic [MEMORY_BITWIDTH-1:0] weight_col;
    logic [MEMORY_BITWIDTH-1:0] sat_vec;

    // Weight storage is deliberately outside the reset domain so it can be
    // loaded while the MAC datapath is held in reset.
    always_ff @(posedge clock) begin
        if (writeEn) begin
            weight_mem[colAddressWrite] <= weightMemInput;
        end
    end

    assign weight_col = weight_mem[colAddressRead];

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state <= ST_ACC;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        acc_en     = 1'b0;
        out_load   = 1'b0;
        case (state)
            ST_ACC: begin
                acc_en = 1'b1;
                if (colAddressRead == LAST_COL) begin
                    state_next = ST_OUT;
                end
            end
            ST_OUT: begin
                out_load   = 1'b1;
                state_next = ST_DONE;
            end
            ST_DONE: begin
                state_next = ST_DONE;
            end
            default: begin
                state_next = ST_ACC;
            end
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            colAddressRead <= '0;
        end else if (acc_en && (colAddressRead != LAST_COL)) begin
            colAddressRead <= colAddressRead + ADDR_BITWIDTH'(1);
        end
    end

    for (genvar r = 0; r < NROW; r++) begin : g_row
        logic signed [BITWIDTH-1:0]   weight;
        logic signed [2*BITWIDTH-1:0] prod;
        logic signed [ACC_W-1:0]      acc;
        logic signed [ACC_W-1:0]      acc_shift;

        assign weight = weight_col[r*BITWIDTH +: BITWIDTH];

        if (DSP48_PER_ROW > 0) begin : g_dsp
            (* use_dsp = "yes" *) logic signed [2*BITWIDTH-1:0] mult;
            assign mult = weight * $signed(inputVec);
            assign prod = mult;
        end else begin : g_fabric
            (* use_dsp = "no" *) logic signed [2*BITWIDTH-1:0] mult;
            assign mult = weight * $signed(inputVec);
            assign prod = mult;
        end

        always_ff @(posedge clock or negedge reset) begin
            if (!reset) begin
                acc <= '0;
            end else if (acc_en) begin
                acc <= acc + {{ADDR_BITWIDTH{prod[2*BITWIDTH-1]}}, prod};
            end
        end

        // Arithmetic shift truncates toward -inf before clamping to BITWIDTH.
        assign acc_shift = acc >>> QM;
        assign sat_vec[r*BITWIDTH +: BITWIDTH] =
            (acc_shift > SAT_MAX) ? SAT_MAX[BITWIDTH-1:0] :
            (acc_shift < SAT_MIN) ? SAT_MIN[BITWIDTH-1:0] :
                                    acc_shift[BITWIDTH-1:0];
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            outputVec <= '0;
            dataReady <= 1'b0;
        end else if (out_load) begin
            outputVec <= sat_vec;
            dataReady <= 1'b1;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_dot_prod_unit.sv
`default_nettype none
// Directed and randomized checks of dot_prod_unit at default parameters.
module tb_dot_prod_unit;

    localparam int NROW = 16;
    localparam int NCOL = 4;
    localparam int BW   = 18;
    localparam int MW   = BW * NROW;

    logic          clock;
    logic          reset;
    logic [1:0]    colAddressWrite;
    logic          writeEn;
    logic [MW-1:0] weightMemInput;
    logic [BW-1:0] inputVec;
    logic [1:0]    colAddressRead;
    logic [MW-1:0] outputVec;
    logic          dataReady;

    int n_vec  = 0;
    int n_miss = 0;

    logic [BW-1:0] w_tb [NROW][NCOL];
    logic [BW-1:0] x_tb [NCOL];
    logic [MW-1:0] exp_vec;

    dot_prod_unit dut (
        .clock          (clock),
        .reset          (reset),
        .colAddressWrite(colAddressWrite),
        .writeEn        (writeEn),
        .weightMemInput (weightMemInput),
        .inputVec       (inputVec),
        .colAddressRead (colAddressRead),
        .outputVec      (outputVec),
        .dataReady      (dataReady)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    task automatic check(input string tag, input logic [MW-1:0] obs, input logic [MW-1:0] exp);
        n_vec++;
        assert (obs === exp)
        else begin
            n_miss++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [MW-1:0] rep(input logic [BW-1:0] v);
        return {NROW{v}};
    endfunction

    // Independent reference: 64-bit sum of products, floor shift, clamp.
    function automatic logic [BW-1:0] model_row(input int r);
        longint acc = 0;
        longint sh;
        for (int c = 0; c < NCOL; c++) begin
            acc += longint'($signed(w_tb[r][c])) * longint'($signed(x_tb[c]));
        end
        sh = acc >>> 11;
        if (sh > 131071)       return 18'h1FFFF;
        else if (sh < -131072) return 18'h20000;
        else                   return sh[BW-1:0];
    endfunction

    task automatic fill_w(input logic [BW-1:0] v);
        for (int r = 0; r < NROW; r++)
            for (int c = 0; c < NCOL; c++)
                w_tb[r][c] = v;
    endtask

    task automatic enter_reset();
        @(negedge clock);
        reset = 1'b0;
    endtask

    task automatic load_weights();
        for (int c = 0; c < NCOL; c++) begin
            @(negedge clock);
            writeEn         = 1'b1;
            colAddressWrite = 2'(c);
            for (int r = 0; r < NROW; r++)
                weightMemInput[r*BW +: BW] = w_tb[r][c];
        end
        @(negedge clock);
        writeEn = 1'b0;
    endtask

    // Releases reset, streams x_tb, and leaves time just after edge NCOL+1.
    task automatic run_vector(input bit detailed);
        @(negedge clock);
        inputVec = x_tb[0];
        reset    = 1'b1;
        for (int c = 0; c < NCOL; c++) begin
            if (detailed) begin
                check("col_step", MW'(colAddressRead), MW'(c));
                check("ready_low_acc", MW'(dataReady), MW'(0));
            end
            @(posedge clock);
            @(negedge clock);
            if (c < NCOL - 1) inputVec = x_tb[c + 1];
        end
        check("col_at_out", MW'(colAddressRead), MW'(3));
        check("ready_low_out", MW'(dataReady), MW'(0));
        @(posedge clock);
        #1;
        check("ready_high", MW'(dataReady), MW'(1));
    endtask

    initial begin
        reset           = 1'b1;
        writeEn         = 1'b0;
        colAddressWrite = '0;
        weightMemInput  = '0;
        inputVec        = '0;
        #3 reset = 1'b0;
        #1;
        check("reset_out", outputVec, '0);
        check("reset_ready", MW'(dataReady), MW'(0));
        check("reset_col", MW'(colAddressRead), MW'(0));

        // W = 1.0, x = [1,2,3,4] -> 10.0
        fill_w(18'h00800);
        load_weights();
        x_tb = '{18'h00800, 18'h01000, 18'h01800, 18'h02000};
        run_vector(1'b1);
        check("ones_result", outputVec, rep(18'h05000));
        repeat (3) @(posedge clock);
        #1;
        check("done_hold_out", outputVec, rep(18'h05000));
        check("done_hold_ready", MW'(dataReady), MW'(1));
        check("done_hold_col", MW'(colAddressRead), MW'(3));

        // Asynchronous abort while DONE
        #2 reset = 1'b0;
        #1;
        check("abort_done_out", outputVec, '0);
        check("abort_done_ready", MW'(dataReady), MW'(0));
        check("abort_done_col", MW'(colAddressRead), MW'(0));

        // Abort after edge 2, then restart with retained weights
        @(negedge clock);
        inputVec = x_tb[0];
        reset    = 1'b1;
        @(posedge clock);
        @(negedge clock);
        inputVec = x_tb[1];
        @(posedge clock);
        #2 reset = 1'b0;
        #1;
        check("abort_mid_out", outputVec, '0);
        check("abort_mid_ready", MW'(dataReady), MW'(0));
        check("abort_mid_col", MW'(colAddressRead), MW'(0));
        run_vector(1'b0);
        check("restart_result", outputVec, rep(18'h05000));

        // W = -0.5, x = 1.0 -> -2.0
        enter_reset();
        fill_w(18'h3FC00);
        load_weights();
        x_tb = '{18'h00800, 18'h00800, 18'h00800, 18'h00800};
        run_vector(1'b0);
        check("neg_half", outputVec, rep(18'h3F000));

        // 31 * 31 * 4 overflows positive, then negative
        enter_reset();
        fill_w(18'h0F800);
        load_weights();
        x_tb = '{18'h0F800, 18'h0F800, 18'h0F800, 18'h0F800};
        run_vector(1'b0);
        check("sat_pos", outputVec, rep(18'h1FFFF));
        enter_reset();
        x_tb = '{18'h30800, 18'h30800, 18'h30800, 18'h30800};
        run_vector(1'b0);
        check("sat_neg", outputVec, rep(18'h20000));

        // Sub-LSB products must accumulate before the shift
        enter_reset();
        fill_w(18'h00001);
        load_weights();
        x_tb = '{18'h00400, 18'h00400, 18'h00400, 18'h00400};
        run_vector(1'b0);
        check("full_precision", outputVec, rep(18'h00002));

        // Mixed-row pattern: row r weight = r * 1.0, x = 1.0 -> y[r] = 4r
        enter_reset();
        for (int r = 0; r < NROW; r++)
            for (int c = 0; c < NCOL; c++)
                w_tb[r][c] = 18'(r * 2048);
        load_weights();
        x_tb = '{18'h00800, 18'h00800, 18'h00800, 18'h00800};
        run_vector(1'b0);
        for (int r = 0; r < NROW; r++)
            exp_vec[r*BW +: BW] = 18'(r * 4 * 2048);
        check("row_ramp", outputVec, exp_vec);

        for (int v = 0; v < 100; v++) begin
            enter_reset();
            for (int r = 0; r < NROW; r++)
                for (int c = 0; c < NCOL; c++)
                    w_tb[r][c] = 18'($urandom);
            for (int c = 0; c < NCOL; c++)
                x_tb[c] = 18'($urandom);
            load_weights();
            run_vector(1'b0);
            for (int r = 0; r < NROW; r++)
                exp_vec[r*BW +: BW] = model_row(r);
            check("random_vec", outputVec, exp_vec);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/dot_prod_unit.md
# dot_prod_unit

Fixed-point matrix-vector multiply engine for the RNN datapath. It holds an NROW x NCOL weight matrix in a column-addressed weight memory and streams one input-vector element per cycle. It produces all NROW dot products in parallel and raises a ready flag when the result vector is valid. It pairs the dot_prod MAC array with its weightRAM, and the gate and layer logic upstream loads weights and consumes results.

## Interface
- NROW, 16, matrix rows, which is also the number of parallel accumulators.
- NCOL, 4, matrix columns, which is also the input vector length. Must be a power of two, ≥2.
- QN, 6, integer bits of the signed fixed-point format.
- QM, 11, fractional bits.
- DSP48_PER_ROW, 2, multiplier-sharing hint. Affects resources only; results and cycle timing are identical for any value.
- Derived: BITWIDTH=QN+QM+1, MEMORY_BITWIDTH=BITWIDTH*NROW, ADDR_BITWIDTH=log2(NCOL).

Ports:
- clock, in, 1, the single clock. All state changes on its rising edge.
- reset, in, 1, asynchronous, active-low. Clears the MAC state only; weight memory contents are not cleared.
- colAddressWrite, in, ADDR_BITWIDTH, weight column to write.
- writeEn, in, 1, weight write strobe.
- weightMemInput, in, MEMORY_BITWIDTH, one weight column. Slice [r*BITWIDTH +: BITWIDTH] = W[r][col].
- inputVec, in, BITWIDTH, signed input element x[colAddressRead].
- colAddressRead, out, ADDR_BITWIDTH, column currently being consumed.
- outputVec, out, MEMORY_BITWIDTH, result. Slice [r*BITWIDTH +: BITWIDTH] = y[r].
- dataReady, out, 1, result valid.

## Operation
- Number format: two's complement, QN.QM, range [-2^QN, 2^QN - 2^-QM]. 1.0 = 2048 at defaults.
- Weight memory: NCOL words of MEMORY_BITWIDTH.
  - Synchronous write at posedge when writeEn=1.
  - Writes are legal while reset is asserted, which is the normal load flow.
  - Read is asynchronous: the column at colAddressRead is visible in the same cycle.
- States are ACC, OUT and DONE. Reset forces:
  - ACC
  - colAddressRead=0
  - all accumulators=0
  - outputVec=0
  - dataReady=0
- ACC, each posedge with reset deasserted:
  - acc[r] += W[r][colAddressRead] * inputVec, for every r.
  - If colAddressRead == NCOL-1, go to OUT. Otherwise increment colAddressRead.
- OUT: outputVec <= sat(acc), dataReady <= 1, go to DONE.
- DONE: hold outputVec, dataReady=1 and colAddressRead=NCOL-1 until reset. There is no auto-restart; each new vector requires a reset pulse.
- Arithmetic:
  - Products are full-precision 2*BITWIDTH with 2*QM fraction bits.
  - Accumulators are 2*BITWIDTH+ADDR_BITWIDTH bits. There is no intermediate rounding.
  - Result = accumulator arithmetic-shifted right by QM (truncate toward -inf), then saturated to [0x20000, 0x1FFFF] at defaults (signed BITWIDTH min/max).

## Timing
- Let edge 1 be the first posedge with reset high. The MACs for columns 0..NCOL-1 happen at edges 1..NCOL. dataReady and outputVec become valid after edge NCOL+1, which is edge 5 at defaults.
- inputVec must be stable at each posedge for the current colAddressRead. It may change on the falling edge.
- Reset asserted mid-accumulation (including in OUT or DONE) aborts immediately and asynchronously: outputs go to 0 and dataReady to 0. Weights are kept. After release, the unit restarts from column 0.
- Writing a column during ACC affects any later read of that column from the next cycle onward. Loading weights while reset is asserted is the supported mode.
- dataReady gets a clean rising edge per vector, because reset forces it low between vectors.

## Test plan
- W all 1.0 (0x00800), x=[1,2,3,4] → every y[r]=10.0 (0x05000). dataReady rises after edge 5. colAddressRead steps 0,1,2,3 and then holds at 3.
- W[r][c]=-0.5 (0x3FC00), x all 1.0 → every y[r]=-2.0 (0x3F000).
- W all 31.0, x all 31.0 → saturate to 0x1FFFF. With x all -31.0 → 0x20000.
- W all 2^-11 (0x00001), x all 0.5 (0x00400) → y=2^-10 (0x00002). This checks full-precision accumulation: truncating each product would give 0.
- Reset pulled low after edge 2 → outputVec=0 and dataReady=0 immediately. After release with the same weights, the full correct result appears after edge 5 of the new run.
- Stream 100 random vectors: reload all weights under reset, release, wait for dataReady, compare all NROW outputs against a bit-accurate model (shift by QM, saturate) with zero mismatches.
